// File: rtl/key_poll_pkg.sv
// Shared types and constants for the key PIO poller: FSM states, PIO register
// address and counter widths.
package key_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } poll_state_t;

    localparam logic [1:0] KEY_PIO_DATA_ADDR = 2'd0;
    localparam int         TIMER_W           = 24;
    localparam int         CNT_W             = 4;

endpackage

// File: rtl/key_debounce.sv
// Sample-count debouncer: a candidate vector must repeat STABLE_COUNT times
// before it becomes key_state; press/release pulse alongside the update.
module key_debounce
    import key_poll_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int STABLE_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_stb,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_COUNT);

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand        <= '0;
            cnt         <= '0;
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            if (sample_stb) begin
                if (sample == cand) begin
                    if (cnt != STABLE) cnt <= cnt + 1'b1;
                end else begin
                    cand <= sample;
                    cnt  <= CNT_W'(1);
                end
            end
            // Commit one edge after the count settles; pulses are derived from the old state.
            if (cnt == STABLE && cand != key_state) begin
                key_state   <= cand;
                key_press   <= cand & ~key_state;
                key_release <= ~cand & key_state;
            end else begin
                key_press   <= '0;
                key_release <= '0;
            end
        end
    end

endmodule

// File: rtl/key_poll_master.sv
// Avalon-MM read-only master that polls the key PIO data register and feeds
// inverted (active-high) samples into the debouncer.
module key_poll_master
    import key_poll_pkg::*;
#(
    parameter int         POLL_PERIOD  = 50000,
    parameter int         READ_LATENCY = 1,
    parameter int         WIDTH        = 2,
    parameter int         STABLE_COUNT = 4,
    parameter logic [1:0] POLL_ADDR    = KEY_PIO_DATA_ADDR
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic             sample_valid
);

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0]   LAT_RELOAD   = CNT_W'(READ_LATENCY - 1);

    poll_state_t        state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   lat;
    logic               capture;
    logic [WIDTH-1:0]   pressed;

    assign avm_address = POLL_ADDR;
    assign capture     = (state == WAIT) && (lat == '0);
    assign pressed     = ~avm_readdata[WIDTH-1:0];

    // Key PIO only drives the low WIDTH bits meaningfully.
    logic unused_readdata;
    assign unused_readdata = &{1'b0, avm_readdata[31:WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= TIMER_RELOAD;
            lat          <= '0;
            avm_read     <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= capture;
            case (state)
                IDLE: begin
                    if (timer == '0) begin
                        timer    <= TIMER_RELOAD;
                        state    <= REQ;
                        avm_read <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        state    <= WAIT;
                        avm_read <= 1'b0;
                        lat      <= LAT_RELOAD;
                    end
                end
                WAIT: begin
                    if (lat == '0) state <= IDLE;
                    else           lat   <= lat - 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

    key_debounce #(
        .WIDTH        (WIDTH),
        .STABLE_COUNT (STABLE_COUNT)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample      (pressed),
        .sample_stb  (capture),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release)
    );

endmodule

// File: tb/tb_key_poll_master.sv
// Directed bench for key_poll_master: poll timing, waitrequest stalls, debounce
// events via a scoreboard, and asynchronous reset mid-transaction.
module tb_key_poll_master;

    localparam int PP = 8;
    localparam int RL = 1;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h3;
    logic [1:0]  key_state, key_press, key_release;
    logic        sample_valid;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
    } exp_t;

    exp_t       q[$];
    logic [1:0] m_cand = 2'b00;
    logic [1:0] m_state = 2'b00;
    int         m_cnt = 0;

    key_poll_master #(
        .POLL_PERIOD  (PP),
        .READ_LATENCY (RL),
        .WIDTH        (2),
        .STABLE_COUNT (SC),
        .POLL_ADDR    (2'd0)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .key_state       (key_state),
        .key_press       (key_press),
        .key_release     (key_release),
        .sample_valid    (sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected debounce outcome for one captured sample.
    task automatic model_push(input logic [31:0] rd);
        logic [1:0] p;
        exp_t       e;
        p = ~rd[1:0];
        if (p == m_cand) begin
            if (m_cnt < SC) m_cnt++;
        end else begin
            m_cand = p;
            m_cnt  = 1;
        end
        e.pr = 2'b00;
        e.rl = 2'b00;
        if (m_cnt == SC && m_cand != m_state) begin
            e.pr    = m_cand & ~m_state;
            e.rl    = ~m_cand & m_state;
            m_state = m_cand;
        end
        e.st = m_state;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_cand  = 2'b00;
        m_state = 2'b00;
        m_cnt   = 0;
        q.delete();
    endtask

    // Entered on the first IDLE cycle; returns on the sample_valid cycle.
    task automatic do_poll(input logic [31:0] rd, input int nwait, input string tag);
        int idle;
        int hi;
        avm_readdata    = rd;
        avm_waitrequest = (nwait > 0);
        model_push(rd);
        idle = 0;
        while (avm_read !== 1'b1 && idle < 100) begin
            idle++;
            @(negedge clk);
        end
        check({tag, " idle_gap"}, idle, PP);
        check({tag, " address"}, avm_address, 32'd0);
        hi = 0;
        while (avm_read === 1'b1 && hi < 100) begin
            hi++;
            if (hi > nwait) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        check({tag, " read_len"}, hi, nwait + 1);
        check({tag, " sv_wait"}, sample_valid, 1'b0);
        @(negedge clk);
        check({tag, " sv_pulse"}, sample_valid, 1'b1);
    endtask

    // Scoreboard: events appear the cycle after sample_valid, and last one cycle.
    initial begin
        int   ph;
        exp_t e;
        ph = 0;
        forever begin
            @(negedge clk);
            if (ph == 2) begin
                check("pulse_end", {key_press, key_release}, 4'b0000);
                ph = 0;
            end else if (ph == 1) begin
                if (q.size() == 0) begin
                    check("sb_underflow", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("sb_state", key_state, e.st);
                    check("sb_press", key_press, e.pr);
                    check("sb_release", key_release, e.rl);
                end
                ph = 2;
            end
            if (sample_valid === 1'b1) ph = 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("rst_read", avm_read, 1'b0);
        check("rst_addr", avm_address, 2'd0);
        check("rst_outs", {key_state, key_press, key_release, sample_valid}, 7'd0);
        reset_n = 1'b1;

        do_poll(32'h3, 0, "idle0");
        do_poll(32'h3, 0, "idle1");
        do_poll(32'h3, 0, "idle2");

        do_poll(32'h2, 0, "bounce0");
        do_poll(32'h3, 0, "bounce1");
        do_poll(32'h2, 0, "bounce2");
        do_poll(32'h3, 0, "bounce3");

        do_poll(32'h2, 0, "press0");
        do_poll(32'h2, 0, "press1");
        do_poll(32'h2, 0, "press2");

        do_poll(32'h2, 5, "stall");
        do_poll(32'h2, 0, "after_stall");

        do_poll(32'hFFFF_FFFD, 0, "swap0");
        do_poll(32'hFFFF_FFFD, 0, "swap1");
        do_poll(32'hFFFF_FFFD, 0, "swap2");
        do_poll(32'hFFFF_FFFD, 0, "hold");

        // Reset while the request is stalled.
        avm_waitrequest = 1'b1;
        t = 0;
        while (avm_read !== 1'b1 && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("mid_req_seen", avm_read, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_read", avm_read, 1'b0);
        check("mid_rst_outs", {key_state, key_press, key_release, sample_valid}, 7'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        do_poll(32'h3, 0, "post_rst0");
        do_poll(32'h2, 0, "post_rst1");

        repeat (3) @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
